keccak_round_sequencer: RTL and testbench



---
 rtl/keccak_round_sequencer_if.sv | 32 +++
 rtl/keccak_round_sequencer.sv | 108 ++++++++++
 tb/tb_keccak_round_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_round_sequencer_if.sv
// Handshake and round-select bundle between the permutation controller,
// the round sequencer and the round-constant decoder / state register.
//   in_valid, in_ready    : permutation request handshake
//   abort                 : cancel of the running or finished permutation
//   round_onehot, round_idx, round_en, first_round : per-round controls
//   out_valid, out_ready  : completion handshake
//   busy                  : sequencer is in RUN or DONE
// Modport slave is the sequencer. Modport master is the requesting controller.
interface keccak_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [23:0] round_onehot;
  logic [4:0]  round_idx;
  logic        round_en;
  logic        first_round;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport slave (
    input  in_valid, abort, out_ready,
    output in_ready, round_onehot, round_idx, round_en, first_round,
           out_valid, busy
  );

  modport master (
    output in_valid, abort, out_ready,
    input  in_ready, round_onehot, round_idx, round_en, first_round,
           out_valid, busy
  );
endinterface

// File: rtl/keccak_round_sequencer.sv
// Keccak round sequencer. It accepts one permutation request. For NR cycles
// it then drives the one-hot round select and the binary round index for
// Keccak-p rounds 24-NR..23. It holds the result-valid flag until the
// consumer takes the result.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : keccak_round_sequencer_if.slave (request, round controls, result)
// Parameter NR (1..24): rounds per permutation.
module keccak_round_sequencer #(
  parameter int NR = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  keccak_round_sequencer_if.slave         bus
);

  if (NR < 1 || NR > 24) begin : g_nr_check
    $error("keccak_round_sequencer: NR must be within 1..24");
  end

  localparam int          FIRST_ROUND  = 24 - NR;
  localparam logic [4:0]  FIRST_IDX    = 5'(FIRST_ROUND);
  localparam logic [23:0] FIRST_ONEHOT = 24'd1 << FIRST_ROUND;
  localparam logic [4:0]  LAST_IDX     = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_n;
  logic [23:0] onehot_r, onehot_n;
  logic [4:0]  idx_r, idx_n;
  logic        first_r, first_n;
  logic        ready_s;

  // The ready path is the only combinational output. An abort in IDLE blocks acceptance.
  assign ready_s = (state_r == IDLE) && !bus.abort;

  assign bus.in_ready     = ready_s;
  assign bus.round_onehot = onehot_r;
  assign bus.round_idx    = idx_r;
  assign bus.first_round  = first_r;
  assign bus.round_en     = (state_r == RUN);
  assign bus.out_valid    = (state_r == DONE);
  assign bus.busy         = (state_r != IDLE);

  // State and round registers. Reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      onehot_r <= 24'd0;
      idx_r    <= 5'd0;
      first_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      onehot_r <= onehot_n;
      idx_r    <= idx_n;
      first_r  <= first_n;
    end
  end

  // Next-state and round-select sequencing. Abort outranks the handshakes.
  always_comb begin
    state_n  = state_r;
    onehot_n = 24'd0;
    idx_n    = 5'd0;
    first_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && ready_s) begin
          state_n  = RUN;
          onehot_n = FIRST_ONEHOT;
          idx_n    = FIRST_IDX;
          first_n  = 1'b1;
        end else begin
          state_n  = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else if (idx_r == LAST_IDX) begin
          // The last round ends here. Clearing the select means it never wraps past bit 23.
          state_n = DONE;
        end else begin
          state_n  = RUN;
          onehot_n = {onehot_r[22:0], 1'b0};
          idx_n    = idx_r + 5'd1;
        end
      end
      DONE: begin
        // No same-cycle turnaround: in_ready is low here, so a new request waits for IDLE.
        if (bus.abort || bus.out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keccak_round_sequencer.sv
// Self-checking bench. It runs three sequencers (NR = 24, 12, 1) side by side.
// Each one is compared every cycle against a timestamp model. The model records
// the cycle in which a request was accepted and derives the round index from
// the elapsed cycles.
module tb_keccak_round_sequencer;
  localparam int NI = 3;
  localparam int NRS [NI] = '{24, 12, 1};
  localparam logic [23:0] FIRST_OH [NI] = '{24'h000001, 24'h001000, 24'h800000};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv [NI];
  logic        ab [NI];
  logic        ordy [NI];
  logic [23:0] oh_w [NI];
  logic [4:0]  idx_w [NI];
  logic        en_w [NI];
  logic        first_w [NI];
  logic        ov_w [NI];
  logic        busy_w [NI];
  logic        ir_w [NI];

  keccak_round_sequencer_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].in_valid  = iv[g];
    assign bus[g].abort     = ab[g];
    assign bus[g].out_ready = ordy[g];
    assign oh_w[g]    = bus[g].round_onehot;
    assign idx_w[g]   = bus[g].round_idx;
    assign en_w[g]    = bus[g].round_en;
    assign first_w[g] = bus[g].first_round;
    assign ov_w[g]    = bus[g].out_valid;
    assign busy_w[g]  = bus[g].busy;
    assign ir_w[g]    = bus[g].in_ready;
    keccak_round_sequencer #(.NR(NRS[g])) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  int total = 0;
  int bad = 0;

  // Model: phase 0 = idle, 1 = running, 2 = result pending; acc = acceptance edge.
  int phase [NI];
  int acc [NI];
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      logic [23:0] e_oh;
      logic [4:0]  e_idx;
      logic        e_en, e_first, e_ov, e_busy, e_ir;
      int          k;
      e_oh = 24'd0; e_idx = 5'd0; e_en = 1'b0; e_first = 1'b0;
      e_ov = 1'b0; e_busy = 1'b0; e_ir = 1'b0;
      if (phase[i] == 0) begin
        e_ir = !ab[i];
      end else if (phase[i] == 1) begin
        k = cyc - acc[i];
        e_idx   = 5'(24 - NRS[i] + k);
        e_oh    = 24'd1 << (24 - NRS[i] + k);
        e_en    = 1'b1;
        e_first = (k == 0);
        e_busy  = 1'b1;
      end else begin
        e_ov   = 1'b1;
        e_busy = 1'b1;
      end
      check($sformatf("onehot%0d", i), 32'(oh_w[i]), 32'(e_oh));
      check($sformatf("idx%0d", i), 32'(idx_w[i]), 32'(e_idx));
      check($sformatf("round_en%0d", i), 32'(en_w[i]), 32'(e_en));
      check($sformatf("first%0d", i), 32'(first_w[i]), 32'(e_first));
      check($sformatf("out_valid%0d", i), 32'(ov_w[i]), 32'(e_ov));
      check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(e_busy));
      check($sformatf("in_ready%0d", i), 32'(ir_w[i]), 32'(e_ir));
      check($sformatf("onehot0_%0d", i), 32'($onehot0(oh_w[i])), 32'd1);
    end
  endtask

  task automatic update_model();
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        phase[i] = 0;
      end else if (phase[i] == 0) begin
        if (iv[i] && !ab[i]) begin
          phase[i] = 1;
          acc[i]   = cyc;
        end
      end else if (phase[i] == 1) begin
        if (ab[i]) phase[i] = 0;
        else if (cyc - acc[i] == NRS[i]) phase[i] = 2;
      end else begin
        if (ab[i] || ordy[i]) phase[i] = 0;
      end
    end
  endtask

  // Called at a falling edge with the inputs already applied.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic set_all(input logic v_iv, input logic v_ab, input logic v_or);
    for (int i = 0; i < NI; i++) begin
      iv[i] = v_iv; ab[i] = v_ab; ordy[i] = v_or;
    end
  endtask

  initial begin
    int lat [NI];
    logic [23:0] fo [NI];
    int last_start [NI];
    int nsp [NI];
    logic seen;
    logic all_found;

    set_all(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin phase[i] = 0; acc[i] = 0; end
    reset = 1'b1;
    @(posedge clk); update_model(); @(negedge clk);
    tick();
    reset = 1'b0;
    tick(); tick();

    // Latency and first round select with backpressure held.
    set_all(1'b1, 1'b0, 1'b0);
    tick();
    set_all(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin lat[i] = -1; fo[i] = oh_w[i]; end
    for (int n = 1; n <= 40; n++) begin
      all_found = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] < 0 && ov_w[i]) lat[i] = n;
        if (lat[i] < 0) all_found = 1'b0;
      end
      if (all_found) break;
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("latency%0d", i), 32'(lat[i]), 32'(NRS[i] + 1));
      check($sformatf("first_onehot%0d", i), 32'(fo[i]), 32'(FIRST_OH[i]));
    end

    // Requests while the result is pending are not accepted. Release with in_valid still high.
    set_all(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) tick();
    set_all(1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < NI; i++) check($sformatf("no_turnaround%0d", i), 32'(busy_w[i]), 32'd0);
    set_all(1'b1, 1'b0, 1'b0);
    tick();
    set_all(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30; n++) tick();

    // Abort instance 0 at round index 7.
    set_all(1'b1, 1'b0, 1'b1);
    tick();
    set_all(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30 && idx_w[0] != 5'd7; n++) tick();
    check("abort_reach_idx7", 32'(idx_w[0]), 32'd7);
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    check("abort_onehot", 32'(oh_w[0]), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (ov_w[0]) seen = 1'b1;
      tick();
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    // An abort in IDLE blocks acceptance.
    set_all(1'b1, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < NI; i++) check($sformatf("abort_idle%0d", i), 32'(busy_w[i]), 32'd0);
    set_all(1'b0, 1'b0, 1'b1);
    tick();

    // Reset in the middle of a run, then a normal request.
    set_all(1'b1, 1'b0, 1'b1);
    tick();
    set_all(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) check($sformatf("reset_midrun%0d", i), 32'(busy_w[i]), 32'd0);
    set_all(1'b1, 1'b0, 1'b1);
    tick();
    set_all(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (ov_w[0]) seen = 1'b1;
      tick();
    end
    check("reset_recover", 32'(seen), 32'd1);

    // Back-to-back: a permutation starts every NR+2 cycles.
    set_all(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NI; i++) begin last_start[i] = -1; nsp[i] = 0; end
    for (int n = 0; n < 90; n++) begin
      for (int i = 0; i < NI; i++) begin
        if (first_w[i]) begin
          if (last_start[i] >= 0 && nsp[i] < 3) begin
            check($sformatf("spacing%0d", i), 32'(cyc - last_start[i]), 32'(NRS[i] + 2));
            nsp[i]++;
          end
          last_start[i] = cyc;
        end
      end
      tick();
    end
    for (int i = 0; i < NI; i++) check($sformatf("spacing_seen%0d", i), 32'(nsp[i] > 0), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NI; i++) begin
        iv[i]   = ($urandom_range(0, 9) < 7);
        ab[i]   = ($urandom_range(0, 99) < 4);
        ordy[i] = ($urandom_range(0, 1) == 1);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    set_all(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
